// File: rtl/arm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multicycle ARM controller: FSM state encoding,
// ALU operation codes, mux select encodings, data-processing command and
// condition-code constants, plus the data-processing ALU decoder.
// -----------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } state_t;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;
    localparam logic [2:0] ALU_SBC = 3'b101;
    localparam logic [2:0] ALU_EOR = 3'b110;

    // Data-processing cmd field (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Instruction op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       shift;     // MOV: pass SrcB straight through
        logic       no_write;  // suppress register write-back
        logic       nz_w;      // op is allowed to update N,Z
        logic       cv_w;      // op is allowed to update C,V
    } alu_dec_t;

    // Unrecognised commands fall back to a harmless ADD that writes nothing.
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{alu_control: ALU_ADD, shift: 1'b0, no_write: 1'b1, nz_w: 1'b0, cv_w: 1'b0};
        case (cmd)
            CMD_ADD: d = '{ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1};
            CMD_SUB: d = '{ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b1};
            CMD_AND: d = '{ALU_AND, 1'b0, 1'b0, 1'b1, 1'b0};
            CMD_ORR: d = '{ALU_ORR, 1'b0, 1'b0, 1'b1, 1'b0};
            CMD_ADC: d = '{ALU_ADC, 1'b0, 1'b0, 1'b1, 1'b1};
            CMD_SBC: d = '{ALU_SBC, 1'b0, 1'b0, 1'b1, 1'b1};
            CMD_EOR: d = '{ALU_EOR, 1'b0, 1'b0, 1'b1, 1'b0};
            CMD_CMP: d = '{ALU_SUB, 1'b0, 1'b1, 1'b1, 1'b1};
            CMD_MOV: d = '{ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// -----------------------------------------------------------------------------
// arm_cond_unit
// Owns the NZCV flag register, evaluates the instruction condition against the
// stored flags and latches the result into cond_ok at the end of DECODE.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cond           instruction condition field
//   alu_flags      NZCV produced by the ALU this cycle
//   flag_w         [1]: request N,Z update, [0]: request C,V update
//   decode_strobe  high while the FSM is in DECODE
//   cond_ok        latched condition result for the current instruction
//   carry          registered C flag
// -----------------------------------------------------------------------------
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       decode_strobe,
    output logic       cond_ok,
    output logic       carry
);

    logic [3:0] flags;  // {N, Z, C, V}
    logic       n, z, c, v;
    logic       cond_ex;

    assign {n, z, c, v} = flags;
    assign carry        = c;

    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;  // 1111 never executes
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags   <= 4'b0000;
            cond_ok <= 1'b0;
        end else begin
            // Flag writes are conditional on the instruction actually executing.
            if (flag_w[1] && cond_ok) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ok) flags[1:0] <= alu_flags[1:0];
            if (decode_strobe)        cond_ok    <= cond_ex;
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// -----------------------------------------------------------------------------
// arm_mc_controller
// Multicycle sequencer for the ARM datapath (data-processing, LDR/STR, B).
// Walks a per-instruction FSM and drives every datapath select, enable and
// ALU control; the condition/flag logic lives in arm_cond_unit.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   Instr[19:0]        instruction bits [31:12]: cond, op, funct, Rn, Rd
//   ALUFlags           NZCV from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite   enables
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc   mux selects
//   ALUControl, Shift  ALU operation / MOV pass-through
//   carry              registered C flag for the ALU carry input
// -----------------------------------------------------------------------------
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        Shift,
    output logic        carry
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = &{1'b0, Instr[7:4]};

    state_t   state, state_next;
    alu_dec_t dec;
    logic     s_bit, in_execute, rd_is_pc;
    logic     cond_ok, write_ok;
    logic     pc_write_fetch, pc_write_raw, reg_write_raw, mem_write_raw;
    logic [1:0] flag_w;

    assign dec        = alu_decode(funct[4:1]);
    assign s_bit      = funct[0] | (funct[4:1] == CMD_CMP);
    assign in_execute = (state == EXECUTER) || (state == EXECUTEI);
    assign rd_is_pc   = (rd == 4'hF);
    assign flag_w     = {dec.nz_w & s_bit & in_execute, dec.cv_w & s_bit & in_execute};

    arm_cond_unit u_cond (
        .clk           (clk),
        .reset         (reset),
        .cond          (cond),
        .alu_flags     (ALUFlags),
        .flag_w        (flag_w),
        .decode_strobe (state == DECODE),
        .cond_ok       (cond_ok),
        .carry         (carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;  // undefined op: no side effects
                endcase
            end
            MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;  // MEMWB, MEMWRITE, ALUWB, BRANCH
        endcase
    end

    // Moore outputs (architectural enables are raw here, gated below)
    always_comb begin
        pc_write_fetch = 1'b0;
        pc_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        mem_write_raw  = 1'b0;
        IRWrite        = 1'b0;
        AdrSrc         = 1'b0;
        RegSrc         = 2'b00;
        ALUSrcA        = 1'b0;
        ALUSrcB        = SRCB_REG;
        ResultSrc      = RES_ALUOUT;
        ALUControl     = ALU_ADD;
        Shift          = 1'b0;
        case (state)
            FETCH: begin
                IRWrite        = 1'b1;
                ALUSrcA        = 1'b1;
                ALUSrcB        = SRCB_FOUR;
                ResultSrc      = RES_ALURESULT;
                pc_write_fetch = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                RegSrc    = {op == OP_MEM, op == OP_BR};
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;  // U bit
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                pc_write_raw  = rd_is_pc;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                RegSrc        = 2'b10;
            end
            EXECUTER: begin
                ALUControl = dec.alu_control;
                Shift      = dec.shift;
            end
            EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec.alu_control;
                Shift      = dec.shift;
            end
            ALUWB: begin
                reg_write_raw = ~dec.no_write;
                pc_write_raw  = rd_is_pc & ~dec.no_write;
            end
            BRANCH: begin
                RegSrc       = 2'b01;  // RA1 = R15 reads PC+8
                ALUSrcB      = SRCB_IMM;
                ResultSrc    = RES_ALURESULT;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Conditional writes need cond_ok; a reset cycle never commits them.
    assign write_ok = cond_ok & ~reset;
    assign PCWrite  = pc_write_fetch | (pc_write_raw & write_ok);
    assign RegWrite = reg_write_raw & write_ok;
    assign MemWrite = mem_write_raw & write_ok;
    assign ImmSrc   = op;

endmodule

// File: tb/tb_arm_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_arm_mc_controller
// Directed instruction sequences; each cycle's expected control word is pushed
// into a scoreboard queue and a monitor compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_arm_mc_controller;

    logic        clk, reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Shift, carry;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Shift      (Shift),
        .carry      (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,
    //                ALUSrcB,ResultSrc,ImmSrc,ALUControl,Shift,carry}
    logic [18:0] act;
    assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, ALUControl, Shift, carry};

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [1:0] imm = 2'b00;  // op field of the instruction being driven
    logic       c   = 1'b0;   // expected registered carry

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, want);
    endtask

    // Monitor: compare whatever the stimulus queued for this cycle
    always @(negedge clk) begin
        exp_t cur;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check(cur.name, act, cur.v);
        end
    end

    // Hand-encoded control word per state
    function automatic logic [18:0] pk(input logic pcw, mw, rw, irw, adr,
                                       input logic [1:0] rs, input logic asa,
                                       input logic [1:0] asb, res,
                                       input logic [2:0] alc, input logic sh);
        return {pcw, mw, rw, irw, adr, rs, asa, asb, res, imm, alc, sh, c};
    endfunction

    function automatic logic [18:0] fetch_v();
        return pk(1, 0, 0, 1, 0, 2'b00, 1, 2'b10, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [18:0] decode_v(input logic [1:0] rs);
        return pk(0, 0, 0, 0, 0, rs, 1, 2'b10, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [18:0] exec_v(input logic [1:0] asb, input logic [2:0] alc, input logic sh);
        return pk(0, 0, 0, 0, 0, 2'b00, 0, asb, 2'b00, alc, sh);
    endfunction
    function automatic logic [18:0] aluwb_v(input logic rw, pcw);
        return pk(pcw, 0, rw, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] memadr_v(input logic [2:0] alc);
        return pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, alc, 0);
    endfunction
    function automatic logic [18:0] memread_v();
        return pk(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] memwb_v(input logic rw, pcw);
        return pk(pcw, 0, rw, 0, 0, 2'b00, 0, 2'b00, 2'b01, 3'b000, 0);
    endfunction
    function automatic logic [18:0] memwrite_v();
        return pk(0, 1, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] branch_v(input logic pcw);
        return pk(pcw, 0, 0, 0, 0, 2'b01, 0, 2'b01, 2'b10, 3'b000, 0);
    endfunction

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic step(input string name, input logic [18:0] e);
        sb.push_back('{name, e});
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] word);
        Instr = word[31:12];
        imm   = word[27:26];
    endtask

    task automatic run_dp(input string name, input logic [31:0] word, input logic [3:0] fl,
                          input logic [1:0] asb, input logic [2:0] alc, input logic sh,
                          input logic rw, pcw, c_after);
        load(word);
        step({name, "/F"}, fetch_v());
        step({name, "/D"}, decode_v(2'b00));
        ALUFlags = fl;
        step({name, "/EX"}, exec_v(asb, alc, sh));
        c = c_after;
        step({name, "/WB"}, aluwb_v(rw, pcw));
    endtask

    task automatic run_ldr(input string name, input logic [31:0] word, input logic [2:0] alc,
                           input logic pcw);
        load(word);
        step({name, "/F"}, fetch_v());
        step({name, "/D"}, decode_v(2'b10));
        step({name, "/MA"}, memadr_v(alc));
        step({name, "/MR"}, memread_v());
        step({name, "/WB"}, memwb_v(1'b1, pcw));
    endtask

    task automatic run_b(input string name, input logic [31:0] word, input logic pcw);
        load(word);
        step({name, "/F"}, fetch_v());
        step({name, "/D"}, decode_v(2'b01));
        step({name, "/BR"}, branch_v(pcw));
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 20'h0;
        ALUFlags = 4'b0000;
        @(posedge clk);
        #1;
        step("reset_held", fetch_v());
        reset = 1'b0;

        //                 word          flags   asb    alc   sh rw pcw c_after
        run_dp("add",    32'hE0821003, 4'b1111, 2'b00, 3'b000, 0, 1, 0, 0);
        run_dp("cmp_z",  32'hE1500001, 4'b0110, 2'b00, 3'b001, 0, 0, 0, 1);
        ALUFlags = 4'b0000;
        run_b("beq_taken", 32'h0A000002, 1'b1);
        run_dp("cmp_nz", 32'hE1500001, 4'b0000, 2'b00, 3'b001, 0, 0, 0, 0);
        run_b("beq_not", 32'h0A000002, 1'b0);

        run_ldr("ldr", 32'hE5910004, 3'b000, 1'b0);
        load(32'hE5810004);
        step("str/F", fetch_v());
        step("str/D", decode_v(2'b10));
        step("str/MA", memadr_v(3'b000));
        step("str/MW", memwrite_v());
        run_ldr("ldr_pc_sub", 32'hE511F004, 3'b001, 1'b1);

        run_dp("adds_imm", 32'hE2921001, 4'b0010, 2'b01, 3'b000, 0, 1, 0, 1);
        run_dp("ands_keep_c", 32'hE0121003, 4'b0000, 2'b00, 3'b010, 0, 1, 0, 1);
        run_dp("cmp_zonly", 32'hE1500001, 4'b0100, 2'b00, 3'b001, 0, 0, 0, 0);
        run_dp("addne_skip", 32'h10821003, 4'b1111, 2'b00, 3'b000, 0, 0, 0, 0);
        run_dp("mov", 32'hE1A01002, 4'b0000, 2'b00, 3'b000, 1, 1, 0, 0);
        run_dp("orr", 32'hE1821003, 4'b0000, 2'b00, 3'b011, 0, 1, 0, 0);
        run_dp("add_pc", 32'hE082F003, 4'b0000, 2'b00, 3'b000, 0, 1, 1, 0);
        run_dp("cond_nv", 32'hF082F003, 4'b0000, 2'b00, 3'b000, 0, 0, 0, 0);

        load(32'hEC000000);
        step("undef/F", fetch_v());
        step("undef/D", decode_v(2'b00));

        run_dp("cmp_c", 32'hE1500001, 4'b0010, 2'b00, 3'b001, 0, 0, 0, 1);

        // Reset during MEMREAD: flags clear, next cycle is FETCH
        load(32'hE5910004);
        step("rst_ldr/F", fetch_v());
        step("rst_ldr/D", decode_v(2'b10));
        step("rst_ldr/MA", memadr_v(3'b000));
        reset = 1'b1;
        step("rst_ldr/MR", memread_v());
        reset = 1'b0;
        c = 1'b0;

        // Reset during MEMWB: write-back must not commit
        step("rst_wb/F", fetch_v());
        step("rst_wb/D", decode_v(2'b10));
        step("rst_wb/MA", memadr_v(3'b000));
        step("rst_wb/MR", memread_v());
        reset = 1'b1;
        step("rst_wb/WB", memwb_v(1'b0, 1'b0));
        reset = 1'b0;
        step("after_rst/F", fetch_v());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
